// File: rtl/ad9837_cmd_seq.sv
// AD9837 command sequencer: turns host config/frequency/phase/reset requests into
// 16-bit AD9837 words and hands them to a shared SPI master with per-device chip selects.
module ad9837_cmd_seq #(
    parameter int unsigned NUM_DEV    = 1,
    parameter int unsigned FREQ_W     = 28,
    parameter int unsigned GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_DEV-1:0] dev_mask,
    input  logic               cfg_wr,
    input  logic               fsel,
    input  logic               psel,
    input  logic               sleep1,
    input  logic               sleep12,
    input  logic               opbiten,
    input  logic               div2,
    input  logic               mode,
    input  logic               fwrq,
    input  logic               freg,
    input  logic [FREQ_W-1:0]  fcode,
    input  logic               phwr,
    input  logic               preg,
    input  logic [11:0]        phase,
    input  logic               soft_reset,
    input  logic               busy,
    output logic               enable,
    output logic [15:0]        tx_data,
    output logic [NUM_DEV-1:0] spi_cs,
    output logic               ready,
    output logic               drop
);

    localparam int unsigned GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SEND, S_WAIT_HI, S_WAIT_LO, S_GAP
    } state_t;

    // Q_RST covers both the post-reset INIT and a host soft reset.
    typedef enum logic [1:0] {Q_RST, Q_CFG, Q_FRQ, Q_PH} seq_t;

    typedef struct packed {
        logic fsel;
        logic psel;
        logic sleep1;
        logic sleep12;
        logic opbiten;
        logic div2;
        logic mode;
    } cfg_t;

    state_t             state_q, state_d;
    seq_t               seq_q, seq_d;
    logic [1:0]         widx_q, widx_d;
    logic [GAP_W-1:0]   gap_q, gap_d;
    cfg_t               cfg_q, cfg_d;
    logic               freg_q, freg_d;
    logic [27:0]        fcode_q, fcode_d;
    logic               preg_q, preg_d;
    logic [11:0]        phase_q, phase_d;
    logic               enable_d;
    logic [15:0]        tx_data_d;
    logic [NUM_DEV-1:0] spi_cs_d;
    logic               ready_d;
    logic               drop_d;

    logic [15:0]        word_c;
    logic               last_c;
    logic               req_c;
    logic [1:0]         fpfx_c;

    function automatic logic [15:0] ctrl_word(input cfg_t c, input logic rst);
        return 16'h2000 | {4'b0000, c.fsel, c.psel, 1'b0, rst, c.sleep1, c.sleep12,
                           c.opbiten, 1'b0, c.div2, 1'b0, c.mode, 1'b0};
    endfunction

    // Word selection for the current sequence position.
    always_comb begin
        word_c = 16'h0000;
        last_c = 1'b1;
        fpfx_c = freg_q ? 2'b10 : 2'b01;
        case (seq_q)
            Q_RST: begin
                word_c = ctrl_word(cfg_q, (widx_q == 2'd0));
                last_c = (widx_q == 2'd1);
            end
            Q_CFG: begin
                word_c = ctrl_word(cfg_q, 1'b0);
                last_c = 1'b1;
            end
            Q_FRQ: begin
                case (widx_q)
                    2'd0:    word_c = ctrl_word(cfg_q, 1'b0);
                    2'd1:    word_c = {fpfx_c, fcode_q[13:0]};
                    default: word_c = {fpfx_c, fcode_q[27:14]};
                endcase
                last_c = (widx_q == 2'd2);
            end
            // PHASE1 select sits at D13; D12 is don't-care and sent as 0.
            Q_PH: begin
                word_c = {2'b11, preg_q, 1'b0, phase_q};
                last_c = 1'b1;
            end
            default: begin
                word_c = 16'h0000;
                last_c = 1'b1;
            end
        endcase
    end

    assign req_c = soft_reset | fwrq | phwr | cfg_wr;

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        seq_d     = seq_q;
        widx_d    = widx_q;
        gap_d     = gap_q;
        cfg_d     = cfg_q;
        freg_d    = freg_q;
        fcode_d   = fcode_q;
        preg_d    = preg_q;
        phase_d   = phase_q;
        enable_d  = 1'b0;
        tx_data_d = tx_data;
        spi_cs_d  = spi_cs;
        ready_d   = ready;
        drop_d    = req_c & ~ready;

        case (state_q)
            S_IDLE: begin
                if (!ready) begin
                    seq_d    = Q_RST;
                    widx_d   = 2'd0;
                    spi_cs_d = '1;
                    state_d  = S_LOAD;
                end else if (req_c) begin
                    if (cfg_wr) begin
                        cfg_d = cfg_t'({fsel, psel, sleep1, sleep12, opbiten, div2, mode});
                    end
                    if (fwrq) begin
                        freg_d  = freg;
                        fcode_d = 28'(fcode);
                    end
                    if (phwr) begin
                        preg_d  = preg;
                        phase_d = phase;
                    end
                    if (dev_mask == '0) begin
                        drop_d = 1'b1;
                    end else begin
                        state_d  = S_LOAD;
                        ready_d  = 1'b0;
                        widx_d   = 2'd0;
                        spi_cs_d = dev_mask;
                        drop_d   = (soft_reset & (fwrq | phwr)) | (fwrq & phwr);
                        if (soft_reset)  seq_d = Q_RST;
                        else if (fwrq)   seq_d = Q_FRQ;
                        else if (phwr)   seq_d = Q_PH;
                        else             seq_d = Q_CFG;
                    end
                end
            end
            S_LOAD: begin
                tx_data_d = word_c;
                enable_d  = 1'b1;
                state_d   = S_SEND;
            end
            S_SEND: begin
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (busy) state_d = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                if (!busy) begin
                    gap_d   = '0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                    if (last_c) begin
                        state_d  = S_IDLE;
                        ready_d  = 1'b1;
                        spi_cs_d = '0;
                    end else begin
                        widx_d  = widx_q + 2'd1;
                        state_d = S_LOAD;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            seq_q   <= Q_RST;
            widx_q  <= 2'd0;
            gap_q   <= '0;
            cfg_q   <= '0;
            freg_q  <= 1'b0;
            fcode_q <= '0;
            preg_q  <= 1'b0;
            phase_q <= '0;
            enable  <= 1'b0;
            tx_data <= '0;
            spi_cs  <= '0;
            ready   <= 1'b0;
            drop    <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            widx_q  <= widx_d;
            gap_q   <= gap_d;
            cfg_q   <= cfg_d;
            freg_q  <= freg_d;
            fcode_q <= fcode_d;
            preg_q  <= preg_d;
            phase_q <= phase_d;
            enable  <= enable_d;
            tx_data <= tx_data_d;
            spi_cs  <= spi_cs_d;
            ready   <= ready_d;
            drop    <= drop_d;
        end
    end

endmodule

// File: tb/tb_ad9837_cmd_seq.sv
// Bench for ad9837_cmd_seq: vector table, randomized requests against an arithmetic
// word model, and hand sequences for INIT, busy-time rejection and mid-sequence reset.
module tb_ad9837_cmd_seq;

    localparam int unsigned NDEV     = 4;
    localparam int unsigned GAP      = 2;
    localparam int unsigned BUSY_LEN = 8;

    logic            clk, reset;
    logic [NDEV-1:0] dev_mask;
    logic            cfg_wr, fsel, psel, sleep1, sleep12, opbiten, div2, mode;
    logic            fwrq, freg, phwr, preg, soft_reset, busy;
    logic [27:0]     fcode;
    logic [11:0]     phase;
    logic            enable, ready, drop;
    logic [15:0]     tx_data;
    logic [NDEV-1:0] spi_cs;

    ad9837_cmd_seq #(.NUM_DEV(NDEV), .FREQ_W(28), .GAP_CYCLES(GAP)) dut (
        .clk(clk), .reset(reset), .dev_mask(dev_mask), .cfg_wr(cfg_wr),
        .fsel(fsel), .psel(psel), .sleep1(sleep1), .sleep12(sleep12),
        .opbiten(opbiten), .div2(div2), .mode(mode), .fwrq(fwrq), .freg(freg),
        .fcode(fcode), .phwr(phwr), .preg(preg), .phase(phase),
        .soft_reset(soft_reset), .busy(busy), .enable(enable), .tx_data(tx_data),
        .spi_cs(spi_cs), .ready(ready), .drop(drop)
    );

    typedef struct packed {
        logic        sr, fw, ph, cw;
        logic [6:0]  cfg;      // {fsel,psel,sleep1,sleep12,opbiten,div2,mode}
        logic        freg;
        logic [27:0] fcode;
        logic        preg;
        logic [11:0] phase;
        logic [3:0]  mask;
        logic [1:0]  n;
        logic [15:0] w0, w1, w2;
        logic        drop;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] log_w[$];
    logic [3:0]  log_cs[$];
    int          drop_cnt;
    logic [6:0]  m_cfg;
    vec_t        vecs[10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, need 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // SPI master model plus protocol monitor, all on the falling edge.
    int          busy_cnt, since_fall;
    logic        prev_en, seen_fall;
    logic [15:0] cur_w;
    initial begin
        busy = 1'b0; busy_cnt = 0; prev_en = 1'b0; seen_fall = 1'b0;
        since_fall = 0; drop_cnt = 0; cur_w = '0;
    end
    always @(negedge clk) begin
        if (enable) begin
            log_w.push_back(tx_data);
            log_cs.push_back(spi_cs);
            check("enable_one_cycle", 32'(prev_en), 0);
            check("busy_idle_at_enable", 32'(busy), 0);
            if (seen_fall) begin
                checks++;
                if (since_fall < int'(GAP)) begin
                    errors++;
                    $display("FAIL gap: %0d idle cycles, need >= %0d", since_fall, GAP);
                end
            end
            busy = 1'b1; busy_cnt = BUSY_LEN; cur_w = tx_data; seen_fall = 1'b0;
        end else if (busy) begin
            if (!reset) check("tx_data_stable", 32'(tx_data), 32'(cur_w));
            busy_cnt--;
            if (busy_cnt == 0) begin
                busy = 1'b0; seen_fall = 1'b1; since_fall = 0;
            end
        end else begin
            since_fall++;
        end
        prev_en = enable;
        if (drop) drop_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic [3:0] ops, input logic [6:0] cfg, input logic fr,
                                input logic [27:0] fc, input logic pr, input logic [11:0] ph,
                                input logic [3:0] mask, input logic [1:0] n, input logic [15:0] w0,
                                input logic [15:0] w1, input logic [15:0] w2, input logic dr);
        vec_t v;
        {v.sr, v.fw, v.ph, v.cw} = ops;
        v.cfg = cfg; v.freg = fr; v.fcode = fc; v.preg = pr; v.phase = ph; v.mask = mask;
        v.n = n; v.w0 = w0; v.w1 = w1; v.w2 = w2; v.drop = dr;
        return v;
    endfunction

    function automatic logic [15:0] cw_m(input logic [6:0] c, input logic rst);
        int s;
        s = 8192 + (c[6] ? 2048 : 0) + (c[5] ? 1024 : 0) + (rst ? 256 : 0) + (c[4] ? 128 : 0)
            + (c[3] ? 64 : 0) + (c[2] ? 32 : 0) + (c[1] ? 8 : 0) + (c[0] ? 2 : 0);
        return 16'(s);
    endfunction

    // Expected words from the request rules, using the model's current config.
    task automatic predict(inout vec_t v);
        logic [6:0] c;
        int         p;
        c = v.cw ? v.cfg : m_cfg;
        v.w0 = '0; v.w1 = '0; v.w2 = '0;
        if (v.mask == '0) begin
            v.n = 2'd0; v.drop = 1'b1;
        end else begin
            v.drop = (v.sr && (v.fw || v.ph)) || (v.fw && v.ph);
            if (v.sr) begin
                v.n = 2'd2; v.w0 = cw_m(c, 1'b1); v.w1 = cw_m(c, 1'b0);
            end else if (v.fw) begin
                p = v.freg ? 32768 : 16384;
                v.n = 2'd3; v.w0 = cw_m(c, 1'b0);
                v.w1 = 16'(p + int'(v.fcode) % 16384);
                v.w2 = 16'(p + int'(v.fcode) / 16384);
            end else if (v.ph) begin
                v.n = 2'd1; v.w0 = 16'(49152 + (v.preg ? 8192 : 0) + int'(v.phase));
            end else begin
                v.n = 2'd1; v.w0 = cw_m(c, 1'b0);
            end
        end
    endtask

    task automatic drive(input vec_t v);
        soft_reset = v.sr; fwrq = v.fw; phwr = v.ph; cfg_wr = v.cw;
        {fsel, psel, sleep1, sleep12, opbiten, div2, mode} = v.cfg;
        freg = v.freg; fcode = v.fcode; preg = v.preg; phase = v.phase; dev_mask = v.mask;
    endtask

    task automatic clear_pulses();
        soft_reset = 1'b0; fwrq = 1'b0; phwr = 1'b0; cfg_wr = 1'b0;
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("ready_timeout", 32'(ready), 1);
    endtask

    task automatic check_log(input string tag, input int n, input logic [15:0] w0,
                             input logic [15:0] w1, input logic [15:0] w2, input logic [3:0] cs);
        logic [15:0] ew[3];
        ew[0] = w0; ew[1] = w1; ew[2] = w2;
        check({tag, "_nwords"}, 32'(log_w.size()), 32'(n));
        for (int i = 0; i < n && i < log_w.size(); i++) begin
            check($sformatf("%s_word%0d", tag, i), 32'(log_w[i]), 32'(ew[i]));
            check($sformatf("%s_cs%0d", tag, i), 32'(log_cs[i]), 32'(cs));
        end
    endtask

    // Issue one request at a falling edge and check latency, words, chip selects and drop.
    task automatic apply(input vec_t v, input string tag);
        int d0;
        log_w.delete(); log_cs.delete();
        d0 = drop_cnt;
        drive(v);
        @(negedge clk);
        clear_pulses();
        if (v.n != 2'd0) begin
            check({tag, "_ready_low"}, 32'(ready), 0);
            @(negedge clk);
            check({tag, "_enable_lat"}, 32'(enable), 1);
            wait_ready();
        end else begin
            check({tag, "_ready_hold"}, 32'(ready), 1);
            repeat (6) @(negedge clk);
        end
        @(negedge clk);
        check_log(tag, int'(v.n), v.w0, v.w1, v.w2, v.mask);
        check({tag, "_drop"}, 32'(drop_cnt - d0), 32'(v.drop));
        check({tag, "_cs_idle"}, 32'(spi_cs), 0);
        if (v.cw) m_cfg = v.cfg;
    endtask

    initial begin
        vec_t v;
        int   d0, k;

        reset = 1'b1; dev_mask = '0; clear_pulses();
        drive(mk(4'b0000, 7'h0, 1'b0, 28'h0, 1'b0, 12'h0, 4'h0, 2'd0, 16'h0, 16'h0, 16'h0, 1'b0));
        m_cfg = '0;
        repeat (3) @(negedge clk);
        check("rst_enable", 32'(enable), 0);
        check("rst_tx_data", 32'(tx_data), 0);
        check("rst_spi_cs", 32'(spi_cs), 0);
        check("rst_ready", 32'(ready), 0);
        check("rst_drop", 32'(drop), 0);

        // Power-up INIT to every device.
        log_w.delete(); log_cs.delete();
        reset = 1'b0;
        @(negedge clk);
        check("init_ready_low", 32'(ready), 0);
        wait_ready();
        @(negedge clk);
        check_log("init", 2, 16'h2100, 16'h2000, 16'h0, 4'hF);

        // ops = {soft_reset, fwrq, phwr, cfg_wr}
        vecs[0] = mk(4'b0100, 7'h00, 1'b0, 28'h0008312, 1'b0, 12'h000, 4'b0001, 2'd3, 16'h2000, 16'h4312, 16'h4002, 1'b0);
        vecs[1] = mk(4'b1100, 7'h00, 1'b0, 28'h0000777, 1'b0, 12'h000, 4'b0011, 2'd2, 16'h2100, 16'h2000, 16'h0000, 1'b1);
        vecs[2] = mk(4'b0001, 7'b1000110, 1'b0, 28'h0, 1'b0, 12'h000, 4'b0001, 2'd1, 16'h2828, 16'h0000, 16'h0000, 1'b0);
        vecs[3] = mk(4'b0100, 7'h00, 1'b1, 28'hFFFFFFF, 1'b0, 12'h000, 4'b0001, 2'd3, 16'h2828, 16'hBFFF, 16'hBFFF, 1'b0);
        vecs[4] = mk(4'b0010, 7'h00, 1'b0, 28'h0, 1'b1, 12'hABC, 4'b0101, 2'd1, 16'hEABC, 16'h0000, 16'h0000, 1'b0);
        vecs[5] = mk(4'b0011, 7'b0000001, 1'b0, 28'h0, 1'b0, 12'h123, 4'b1000, 2'd1, 16'hC123, 16'h0000, 16'h0000, 1'b0);
        vecs[6] = mk(4'b0100, 7'h00, 1'b0, 28'h0000000, 1'b0, 12'h000, 4'b0010, 2'd3, 16'h2002, 16'h4000, 16'h4000, 1'b0);
        vecs[7] = mk(4'b0101, 7'b0110000, 1'b0, 28'h0004001, 1'b0, 12'h000, 4'b1111, 2'd3, 16'h2480, 16'h4001, 16'h4001, 1'b0);
        vecs[8] = mk(4'b0110, 7'h00, 1'b1, 28'h0000005, 1'b0, 12'hFFF, 4'b0100, 2'd3, 16'h2480, 16'h8005, 16'h8000, 1'b1);
        vecs[9] = mk(4'b0100, 7'h00, 1'b0, 28'h0001234, 1'b0, 12'h000, 4'b0000, 2'd0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        for (int i = 0; i < 10; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // A frequency write arriving while a phase word is on the wire is dropped.
        log_w.delete(); log_cs.delete();
        d0 = drop_cnt;
        drive(mk(4'b0010, 7'h00, 1'b0, 28'h0, 1'b0, 12'h055, 4'b0001, 2'd0, 16'h0, 16'h0, 16'h0, 1'b0));
        @(negedge clk);
        clear_pulses();
        k = 0;
        while (!busy && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("busydrop_busy_seen", 32'(busy), 1);
        fwrq = 1'b1; freg = 1'b1; fcode = 28'h1;
        @(negedge clk);
        fwrq = 1'b0;
        wait_ready();
        @(negedge clk);
        check_log("busydrop", 1, 16'hC055, 16'h0, 16'h0, 4'b0001);
        check("busydrop_drop", 32'(drop_cnt - d0), 1);

        // Randomized requests against the model.
        for (int i = 0; i < 30; i++) begin
            v = mk(4'(($urandom_range(1, 15))), 7'($urandom), 1'($urandom), 28'($urandom),
                   1'($urandom), 12'($urandom),
                   ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                   2'd0, 16'h0, 16'h0, 16'h0, 1'b0);
            predict(v);
            apply(v, $sformatf("rnd%0d", i));
        end

        // Reset during the second word of a frequency write.
        log_w.delete(); log_cs.delete();
        drive(mk(4'b0100, 7'h00, 1'b0, 28'h1234567, 1'b0, 12'h0, 4'b0110, 2'd0, 16'h0, 16'h0, 16'h0, 1'b0));
        @(negedge clk);
        clear_pulses();
        k = 0;
        while (log_w.size() < 2 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("mid_second_word", 32'(log_w.size()), 2);
        repeat (2) @(negedge clk);
        check("mid_cs_before", 32'(spi_cs), 32'(4'b0110));
        reset = 1'b1;
        @(negedge clk);
        check("mid_enable", 32'(enable), 0);
        check("mid_spi_cs", 32'(spi_cs), 0);
        check("mid_ready", 32'(ready), 0);
        repeat (12) @(negedge clk);
        check("mid_no_third", 32'(log_w.size()), 2);
        log_w.delete(); log_cs.delete();
        m_cfg = '0;
        reset = 1'b0;
        wait_ready();
        @(negedge clk);
        check_log("reinit", 2, 16'h2100, 16'h2000, 16'h0, 4'hF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
